// File: rtl/fc_spi_slave.sv
// SPI mode-0 slave bridging flight-computer frames onto the FPGA register map.
// 32-bit frames: 16-bit command (bit 15 = read, 14:0 = address) then 16-bit data.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no frame; MISO released, waits for slave select low
// CMD      | shifting in the 16 command bits
// RD_FETCH | rd_en held for RD_LATENCY+1 cycles, read data captured at end
// DATA     | shifting write data in, or read data out on MISO
// DONE     | frame finished (or reset mid-frame); waits for slave select high
`timescale 1ns/1ps
module fc_spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic        clk210_p,
  input  logic        reset_p,
  input  logic        fc_spi_sclk_p,
  input  logic        fc_spi_ss_n_p,
  input  logic        fc_spi_mosi_p,
  output logic        fc_spi_miso_p,
  output logic        fc_spi_miso_oe_p,
  output logic [15:0] memory_map_spi_wr_addr_p,
  output logic [15:0] memory_map_spi_wr_data_p,
  output logic        memory_map_spi_wr_en_p,
  output logic [15:0] memory_map_spi_rd_addr_p,
  output logic        memory_map_spi_rd_en_p,
  input  logic [15:0] memory_map_spi_rd_data_p,
  output logic [15:0] spi_frame_count_p,
  output logic [15:0] spi_abort_count_p,
  output logic        spi_busy_p
);

  localparam int LAT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD_FETCH,
    ST_DATA,
    ST_DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_n_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   sclk_s;
  logic                   ss_n_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   abort;
  logic [5:0]             bit_cnt;
  logic [14:0]            rx;
  logic [15:0]            tx;
  logic                   is_rd;
  logic [LAT_W-1:0]       fetch_cnt;

  // ss_n resets low so a frame already running at reset release is never decoded
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      sclk_sync <= '0;
      ss_n_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], fc_spi_sclk_p};
      ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], fc_spi_ss_n_p};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], fc_spi_mosi_p};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_n_s    = ss_n_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign abort     = ss_n_s && (state == ST_CMD || state == ST_RD_FETCH || state == ST_DATA);

  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      state                    <= ST_DONE;
      bit_cnt                  <= '0;
      rx                       <= '0;
      tx                       <= '0;
      is_rd                    <= 1'b0;
      fetch_cnt                <= '0;
      fc_spi_miso_oe_p         <= 1'b0;
      memory_map_spi_wr_addr_p <= '0;
      memory_map_spi_wr_data_p <= '0;
      memory_map_spi_wr_en_p   <= 1'b0;
      memory_map_spi_rd_addr_p <= '0;
      memory_map_spi_rd_en_p   <= 1'b0;
      spi_frame_count_p        <= '0;
      spi_abort_count_p        <= '0;
    end else begin
      memory_map_spi_wr_en_p <= 1'b0;
      if (abort) begin
        // slave select wins over a coincident 32nd rise
        state                  <= ST_IDLE;
        memory_map_spi_rd_en_p <= 1'b0;
        fc_spi_miso_oe_p       <= 1'b0;
        spi_abort_count_p      <= spi_abort_count_p + 16'd1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!ss_n_s) begin
              state            <= ST_CMD;
              bit_cnt          <= '0;
              rx               <= '0;
              tx               <= '0;
              fc_spi_miso_oe_p <= 1'b1;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              rx      <= {rx[13:0], mosi_s};
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd15) begin
                is_rd <= rx[14];
                if (rx[14]) begin
                  memory_map_spi_rd_addr_p <= {1'b0, rx[13:0], mosi_s};
                  memory_map_spi_rd_en_p   <= 1'b1;
                  fetch_cnt                <= LAT_W'(RD_LATENCY);
                  state                    <= ST_RD_FETCH;
                end else begin
                  memory_map_spi_wr_addr_p <= {1'b0, rx[13:0], mosi_s};
                  state                    <= ST_DATA;
                end
              end
            end
          end
          ST_RD_FETCH: begin
            if (fetch_cnt == '0) begin
              tx                     <= memory_map_spi_rd_data_p;
              memory_map_spi_rd_en_p <= 1'b0;
              state                  <= ST_DATA;
            end else begin
              fetch_cnt <= fetch_cnt - LAT_W'(1);
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              rx      <= {rx[13:0], mosi_s};
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd31) begin
                if (!is_rd) begin
                  memory_map_spi_wr_data_p <= {rx, mosi_s};
                  memory_map_spi_wr_en_p   <= 1'b1;
                end
                spi_frame_count_p <= spi_frame_count_p + 16'd1;
                state             <= ST_DONE;
              end
            end else if (sclk_fall && is_rd && bit_cnt >= 6'd17) begin
              tx <= {tx[14:0], 1'b0};
            end
          end
          ST_DONE: begin
            if (ss_n_s) begin
              state            <= ST_IDLE;
              fc_spi_miso_oe_p <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign fc_spi_miso_p = (state == ST_DATA) && is_rd && tx[15];
  assign spi_busy_p    = (state != ST_IDLE);

endmodule

// File: tb/tb_fc_spi_slave.sv
// Bench acting as the flight computer: sends frames, models the register map,
// and checks strobes, MISO bits and counters against a frame-level model.
`timescale 1ns/1ps
module tb_fc_spi_slave;

  localparam int SYNC_STAGES = 2;
  localparam int RD_LATENCY  = 1;

  logic        clk210_p = 1'b0;
  logic        reset_p;
  logic        sclk;
  logic        ss_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic [15:0] rd_data = 16'h0;
  logic [15:0] frame_count;
  logic [15:0] abort_count;
  logic        busy;

  always #5 clk210_p = ~clk210_p;

  fc_spi_slave #(.SYNC_STAGES(SYNC_STAGES), .RD_LATENCY(RD_LATENCY)) dut (
    .clk210_p                 (clk210_p),
    .reset_p                  (reset_p),
    .fc_spi_sclk_p            (sclk),
    .fc_spi_ss_n_p            (ss_n),
    .fc_spi_mosi_p            (mosi),
    .fc_spi_miso_p            (miso),
    .fc_spi_miso_oe_p         (miso_oe),
    .memory_map_spi_wr_addr_p (wr_addr),
    .memory_map_spi_wr_data_p (wr_data),
    .memory_map_spi_wr_en_p   (wr_en),
    .memory_map_spi_rd_addr_p (rd_addr),
    .memory_map_spi_rd_en_p   (rd_en),
    .memory_map_spi_rd_data_p (rd_data),
    .spi_frame_count_p        (frame_count),
    .spi_abort_count_p        (abort_count),
    .spi_busy_p               (busy)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  wr_t         wr_got;
  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_frames = 0;
  int          exp_aborts = 0;
  int          wr_strobes = 0;
  int          last_rd_run = 0;
  int          rd_run = 0;
  int          ss_hi_cnt = 0;
  logic        wr_prev = 1'b0;
  logic [39:0] mb;
  logic [15:0] mword;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  function automatic logic [15:0] map_val(input logic [15:0] a);
    if (a == 16'h0052) return 16'h07D0;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // register map: data valid one cycle after rd_en, garbage otherwise
  always @(posedge clk210_p) rd_data <= rd_en ? map_val(rd_addr) : 16'($urandom);

  function automatic logic [15:0] miso_word(input logic [39:0] bits);
    logic [15:0] w;
    for (int k = 0; k < 16; k++) w[15-k] = bits[16+k];
    return w;
  endfunction

  initial begin
    forever begin
      @(posedge clk210_p);
      #1;
      if (reset_p) begin
        wr_prev   = 1'b0;
        rd_run    = 0;
        ss_hi_cnt = 0;
      end else begin
        if (wr_en) begin
          wr_strobes++;
          chk("wr_en_width", {31'd0, wr_prev}, 32'd0);
          if (exp_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
          else begin
            wr_got = exp_wr.pop_front();
            chk("wr_addr", {16'd0, wr_addr}, {16'd0, wr_got.addr});
            chk("wr_data", {16'd0, wr_data}, {16'd0, wr_got.data});
          end
        end
        wr_prev = wr_en;
        if (rd_en) begin
          if (exp_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
          else chk("rd_addr", {16'd0, rd_addr}, {16'd0, exp_rd[0]});
          rd_run++;
        end else if (rd_run > 0) begin
          chk("rd_en_cycles", rd_run, RD_LATENCY + 1);
          last_rd_run = rd_run;
          if (exp_rd.size() > 0) void'(exp_rd.pop_front());
          rd_run = 0;
        end
        ss_hi_cnt = ss_n ? ss_hi_cnt + 1 : 0;
        if (ss_hi_cnt >= SYNC_STAGES + 1) begin
          chk("busy_idle", {31'd0, busy}, 32'd0);
          chk("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
        end
        if (!miso_oe) chk("miso_released_zero", {31'd0, miso}, 32'd0);
      end
    end
  end

  // rst_bit >= 0 pulses reset before that bit; such a frame must have no effect
  task automatic run_frame(input logic [31:0] word, input int nbits, input int half,
                           input int gap, input int rst_bit, output logic [39:0] bits);
    logic        rd;
    logic [15:0] addr;
    logic [15:0] mv;
    logic        eb;
    rd   = word[31];
    addr = {1'b0, word[30:16]};
    mv   = map_val(addr);
    bits = '0;
    if (rst_bit < 0) begin
      if (nbits >= 32) begin
        exp_frames++;
        if (!rd) exp_wr.push_back({addr, word[15:0]});
      end else exp_aborts++;
      if (rd && nbits >= 16) exp_rd.push_back(addr);
    end
    @(negedge clk210_p);
    ss_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        reset_p = 1'b1;
        repeat (2) @(negedge clk210_p);
        reset_p    = 1'b0;
        exp_frames = 0;
        exp_aborts = 0;
        @(negedge clk210_p);
        chk("busy_after_reset", {31'd0, busy}, 32'd1);
        chk("frames_after_reset", {16'd0, frame_count}, 32'd0);
      end
      mosi = (i < 32) ? word[31-i] : 1'($urandom);
      repeat (half) @(negedge clk210_p);
      sclk = 1'b1;
      eb = 1'b0;
      if (rd && i >= 16 && i < 32) eb = mv[31-i];
      if (i < 40) bits[i] = miso;
      chk("miso_bit", {31'd0, miso}, {31'd0, eb});
      repeat (half) @(negedge clk210_p);
      sclk = 1'b0;
    end
    repeat (half) @(negedge clk210_p);
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (gap) @(negedge clk210_p);
    chk("frame_count", {16'd0, frame_count}, exp_frames);
    chk("abort_count", {16'd0, abort_count}, exp_aborts);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    int          nb;
    int          kind;
    reset_p = 1'b1;
    sclk    = 1'b0;
    ss_n    = 1'b1;
    mosi    = 1'b0;
    repeat (3) @(negedge clk210_p);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_wr_addr", {16'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
    chk("rst_rd_addr", {16'd0, rd_addr}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_abort_count", {16'd0, abort_count}, 32'd0);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_busy_done", {31'd0, busy}, 32'd1);
    reset_p = 1'b0;
    repeat (5) @(negedge clk210_p);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    run_frame(32'h0053_0001, 32, 10, 6, -1, mb);
    chk("t1_wr_addr", {16'd0, wr_addr}, 32'h0053);
    chk("t1_wr_data", {16'd0, wr_data}, 32'h0001);
    chk("t1_wr_strobes", wr_strobes, 1);
    chk("t1_frame_count", {16'd0, frame_count}, 32'd1);

    run_frame(32'h8052_0000, 32, 10, 6, -1, mb);
    chk("t2_miso_word", {16'd0, miso_word(mb)}, 32'h07D0);
    chk("t2_rd_addr", {16'd0, rd_addr}, 32'h0052);
    chk("t2_rd_cycles", last_rd_run, 2);
    chk("t2_wr_strobes", wr_strobes, 1);
    chk("t2_frame_count", {16'd0, frame_count}, 32'd2);

    run_frame(32'h0033_1234, 20, 10, 6, -1, mb);
    chk("t3_abort_count", {16'd0, abort_count}, 32'd1);
    chk("t3_frame_count", {16'd0, frame_count}, 32'd2);
    chk("t3_wr_strobes", wr_strobes, 1);

    run_frame(32'h0012_BEEF, 40, 10, 6, -1, mb);
    chk("t4_wr_addr", {16'd0, wr_addr}, 32'h0012);
    chk("t4_wr_data", {16'd0, wr_data}, 32'hBEEF);
    chk("t4_wr_strobes", wr_strobes, 2);
    chk("t4_extra_miso", {24'd0, mb[39:32]}, 32'd0);

    run_frame(32'h0044_5555, 32, 10, 6, 5, mb);
    chk("t5_wr_strobes", wr_strobes, 2);
    chk("t5_frame_count", {16'd0, frame_count}, 32'd0);
    run_frame(32'h0045_A5A5, 32, 10, 6, -1, mb);
    chk("t5_wr_addr", {16'd0, wr_addr}, 32'h0045);
    chk("t5_wr_data", {16'd0, wr_data}, 32'hA5A5);
    chk("t5_frame_count_next", {16'd0, frame_count}, 32'd1);

    run_frame(32'h8052_0000, 32, 8, 4, -1, mb);
    chk("t6_miso_word", {16'd0, miso_word(mb)}, 32'h07D0);
    run_frame(32'h0077_1111, 32, 8, 4, -1, mb);
    chk("t6_wr_data", {16'd0, wr_data}, 32'h1111);
    chk("t6_frame_count", {16'd0, frame_count}, 32'd3);

    for (int f = 0; f < 24; f++) begin
      w    = $urandom;
      kind = $urandom_range(0, 9);
      if (kind < 2) nb = $urandom_range(1, 31);
      else if (kind == 2) nb = $urandom_range(33, 40);
      else nb = 32;
      run_frame(w, nb, $urandom_range(8, 12), $urandom_range(4, 8), -1, mb);
    end

    repeat (10) @(negedge clk210_p);
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_reads", exp_rd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
